// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder tree: level count, rounding constant and per-level widths.
package adder_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic int rnd_k(input int q);
    return (q == 0) ? 0 : (1 << (q - 1));
  endfunction

  function automatic int lvl_w(input int in_w, input int k);
    return in_w + k;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the reduction tree: adds lane pairs with one bit of sign-extended growth.
module adder_tree_level
  import adder_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int IN_W    = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  i_en,
  input  logic                                  i_valid,
  input  logic                                  i_last,
  input  logic [N_LANES*IN_W-1:0]               i_data,
  output logic                                  o_valid,
  output logic                                  o_last,
  output logic [(N_LANES/2)*lvl_w(IN_W,1)-1:0]  o_data
);

  localparam int N_OUT = N_LANES / 2;
  localparam int SUM_W = lvl_w(IN_W, 1);

  logic [N_OUT*SUM_W-1:0] w_sum;
  logic [N_OUT*SUM_W-1:0] r_data;
  logic                   r_valid;
  logic                   r_last;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_pair
      logic [IN_W-1:0] w_a;
      logic [IN_W-1:0] w_b;
      assign w_a = i_data[(2*gi)*IN_W +: IN_W];
      assign w_b = i_data[(2*gi+1)*IN_W +: IN_W];
      assign w_sum[gi*SUM_W +: SUM_W] = {w_a[IN_W-1], w_a} + {w_b[IN_W-1], w_b};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_last  <= i_last;
      r_data  <= w_sum;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed reduction tree with packet accumulation, round-half-up Q scaling and valid/ready output.
// Define ADDER_SAT_EN to saturate the final narrowing (and report it on out_sat); otherwise it wraps.
module adder_tree_pipe
  import adder_pkg::*;
#(
  parameter int N_IN     = 16,
  parameter int IN_W     = 16,
  parameter int Q        = 5,
  parameter int ACC_GROW = 6,
  parameter int OUT_W    = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_sat
);

  localparam int L     = clog2(N_IN);
  localparam int S_W   = lvl_w(IN_W, L);
  localparam int ACC_W = S_W + ACC_GROW;
  localparam int RW    = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;
  localparam logic signed [RW-1:0] K_RND = RW'(rnd_k(Q));

  logic                    w_en;
  logic [N_IN*IN_W-1:0]    r_l0_data;
  logic                    r_l0_valid;
  logic                    r_l0_last;
  logic signed [S_W-1:0]   w_s;
  logic                    w_s_valid;
  logic                    w_s_last;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_t;
  logic signed [RW-1:0]    w_rnd;
  logic [OUT_W-1:0]        w_res;
  logic                    w_res_sat;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_sat;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Input capture acts as tree level 0, so lane adds never sit behind the input pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_l0_valid <= 1'b0;
      r_l0_last  <= 1'b0;
      r_l0_data  <= '0;
    end else if (w_en) begin
      r_l0_valid <= in_valid;
      r_l0_last  <= in_last;
      r_l0_data  <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_lvl
      localparam int LN = N_IN >> gi;
      localparam int LW = lvl_w(IN_W, gi);
      logic [LN*LW-1:0]           w_din;
      logic                       w_vin;
      logic                       w_lin;
      logic [(LN/2)*(LW+1)-1:0]   w_dout;
      logic                       w_vout;
      logic                       w_lout;
      if (gi == 0) begin : g_src
        assign w_din = r_l0_data;
        assign w_vin = r_l0_valid;
        assign w_lin = r_l0_last;
      end else begin : g_src
        assign w_din = g_lvl[gi-1].w_dout;
        assign w_vin = g_lvl[gi-1].w_vout;
        assign w_lin = g_lvl[gi-1].w_lout;
      end
      adder_tree_level #(
        .N_LANES (LN),
        .IN_W    (LW)
      ) u_level (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_en),
        .i_valid (w_vin),
        .i_last  (w_lin),
        .i_data  (w_din),
        .o_valid (w_vout),
        .o_last  (w_lout),
        .o_data  (w_dout)
      );
    end
  endgenerate

  assign w_s       = g_lvl[L-1].w_dout;
  assign w_s_valid = g_lvl[L-1].w_vout;
  assign w_s_last  = g_lvl[L-1].w_lout;

  assign w_t   = r_acc + ACC_W'(w_s);
  // One spare bit keeps T + K exact before the shift.
  assign w_rnd = RW'(w_t) + K_RND;

`ifdef ADDER_SAT_EN
  logic signed [RW-1:0]  w_shift;
  logic [RW-OUT_W:0]     w_top;
  logic                  w_clip;
  assign w_shift   = w_rnd >>> Q;
  assign w_top     = w_shift[RW-1:OUT_W-1];
  assign w_clip    = !((&w_top) || !(|w_top));
  assign w_res     = w_clip ? (w_shift[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                            : w_shift[OUT_W-1:0];
  assign w_res_sat = w_clip;
`else
  assign w_res     = OUT_W'(w_rnd >>> Q);
  assign w_res_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= 1'b0;
      if (w_s_valid) begin
        if (w_s_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_res;
          r_out_sat   <= w_res_sat;
          r_acc       <= '0;
        end else begin
          r_acc <= w_t;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Randomised scoreboard bench for adder_tree_pipe; honours ADDER_SAT_EN in its reference model.
module tb_adder_tree_pipe;

  localparam int N_IN     = 16;
  localparam int IN_W     = 16;
  localparam int Q        = 5;
  localparam int ACC_GROW = 6;
  localparam int OUT_W    = 20;
  localparam int L        = 4;
  localparam int ACC_W    = IN_W + L + ACC_GROW;

  typedef struct {
    logic [OUT_W-1:0] d;
    bit               s;
  } exp_t;

  logic                 clk;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*IN_W-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_sat;

  exp_t        sb_q[$];
  logic [IN_W-1:0] lanes [N_IN];
  longint      pkt_sum;
  int          errors;
  int          checks;
  int          edge_cnt;
  int          lat_edge;
  bit          lat_pending;
  bit          hold_ready;
  bit          rand_ready;
  int          hold_cnt;
  int          n_out;

  adder_tree_pipe #(
    .N_IN     (N_IN),
    .IN_W     (IN_W),
    .Q        (Q),
    .ACC_GROW (ACC_GROW),
    .OUT_W    (OUT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: exact packet total, wrapped to the accumulator width, rounded half-up, then narrowed.
  function automatic exp_t ref_result(input longint total);
    exp_t   e;
    longint t, r, maxv, minv;
    t    = (total <<< (64 - ACC_W)) >>> (64 - ACC_W);
    r    = t + ((Q == 0) ? 64'sd0 : (longint'(1) <<< (Q - 1)));
    r    = r >>> Q;
    maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
    minv = -(longint'(1) <<< (OUT_W - 1));
    e.s  = 1'b0;
`ifdef ADDER_SAT_EN
    if (r > maxv) begin
      r   = maxv;
      e.s = 1'b1;
    end else if (r < minv) begin
      r   = minv;
      e.s = 1'b1;
    end
`else
    if (r > maxv || r < minv) r = r;
`endif
    e.d = r[OUT_W-1:0];
    return e;
  endfunction

  task automatic fill(input logic [IN_W-1:0] even_v, input logic [IN_W-1:0] odd_v);
    for (int i = 0; i < N_IN; i++) lanes[i] = (i % 2 == 0) ? even_v : odd_v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N_IN; i++) lanes[i] = IN_W'($urandom);
  endtask

  task automatic send_beat(input bit last);
    bit     ok;
    int     guard;
    longint s;
    ok    = 1'b0;
    guard = 0;
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) in_data[i*IN_W +: IN_W] = lanes[i];
    in_valid = 1'b1;
    in_last  = last;
    while (!ok) begin
      #1;
      ok = in_ready;
      if (ok) lat_edge = edge_cnt + 1;
      @(posedge clk);
      if (!ok) begin
        guard++;
        if (guard > 500) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
          break;
        end
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'($signed(lanes[i]));
      pkt_sum += s;
      if (last) begin
        sb_q.push_back(ref_result(pkt_sum));
        pkt_sum = 0;
      end
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Consumer: forced holds, random backpressure or always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else if (hold_ready) out_ready = 1'b0;
      else if (rand_ready)     out_ready = ($urandom_range(0, 3) != 0);
      else                     out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall behaviour.
  initial begin
    bit               prev_stall;
    logic [OUT_W-1:0] prev_data;
    exp_t             e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (lat_pending && out_valid) begin
        check("latency_edges", edge_cnt - lat_edge, L + 1);
        lat_pending = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, prev_data);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data=0x%05h with empty scoreboard, required no output", out_data);
        end else begin
          e = sb_q.pop_front();
          $display("out %0d: data=0x%05h sat=%0d expected data=0x%05h sat=%0d", n_out, out_data, out_sat, e.d, e.s);
          check("out_data", out_data, e.d);
          check("out_sat", out_sat, e.s);
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int g;
    errors      = 0;
    checks      = 0;
    n_out       = 0;
    pkt_sum     = 0;
    lat_pending = 1'b0;
    lat_edge    = 0;
    hold_ready  = 1'b0;
    rand_ready  = 1'b0;
    hold_cnt    = 0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_data     = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_sat", out_sat, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single beat of 1.0 in every lane, with latency measurement.
    fill(16'h0020, 16'h0020);
    lat_pending = 1'b1;
    send_beat(1'b1);
    wait_drain();
    check("latency_seen", lat_pending, 0);

    // Negative lanes and alternating lanes.
    fill(16'hFFFF, 16'hFFFF);
    send_beat(1'b1);
    fill(16'h0010, 16'h0000);
    send_beat(1'b1);
    wait_drain();

    // Three-beat packet, then a single beat proving the accumulator cleared.
    fill(16'h0020, 16'h0020);
    send_beat(1'b0);
    send_beat(1'b0);
    send_beat(1'b1);
    send_beat(1'b1);
    wait_drain();

    // Back-to-back stream with a 4-cycle consumer hold in the middle.
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          fill_rand();
          send_beat(1'b1);
        end
      end
      begin
        repeat (6) @(negedge clk);
        hold_cnt = 4;
      end
    join
    wait_drain();

    // 40-beat packet of maximum positive lanes: exercises the narrowing.
    fill(16'h7FFF, 16'h7FFF);
    for (int b = 0; b < 39; b++) send_beat(1'b0);
    send_beat(1'b1);
    wait_drain();

    // Random packets under random backpressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 200; b++) begin
      fill_rand();
      send_beat((b == 199) || ($urandom_range(0, 2) == 0));
    end
    wait_drain();
    rand_ready = 1'b0;

    // Asynchronous reset while a result is stalled at the output and a packet is half-built.
    hold_ready = 1'b1;
    @(negedge clk);
    fill(16'h0020, 16'h0020);
    send_beat(1'b1);
    fill(16'h0123, 16'h0456);
    send_beat(1'b0);
    send_beat(1'b0);
    g = 0;
    while (g < 50) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
      g++;
    end
    check("pre_reset_out_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_out_data", out_data, 0);
    check("async_reset_out_sat", out_sat, 0);
    check("async_reset_in_ready", in_ready, 1);
    sb_q.delete();
    pkt_sum    = 0;
    hold_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fill(16'h0020, 16'h0020);
    send_beat(1'b1);
    wait_drain();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
